// File: rtl/clock_gen_pkg.sv
// clock_gen_pkg: shared constants, per-channel configuration type and the
// divisor/high-time clamp helpers used by every clock_gen channel.
// Config fields are CFG_W wide so one struct type serves any CNT_W up to
// CFG_W; the unused upper bits are constant zero and fold away.
package clock_gen_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int CFG_W     = 32;
  localparam int DIV_MIN   = 2;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
  } ch_cfg_t;

  // A period shorter than two cycles cannot have both a high and a low phase
  function automatic logic [CFG_W-1:0] clampDiv(input logic [CFG_W-1:0] div);
    return (div < CFG_W'(DIV_MIN)) ? CFG_W'(DIV_MIN) : div;
  endfunction

  // High time must leave at least one high and one low cycle in the period
  function automatic logic [CFG_W-1:0] clampHigh(input logic [CFG_W-1:0] high,
                                                 input logic [CFG_W-1:0] div);
    logic [CFG_W-1:0] h;
    h = high;
    if (h == '0) h = CFG_W'(1);
    if (h > div - CFG_W'(1)) h = div - CFG_W'(1);
    return h;
  endfunction

endpackage

// File: rtl/clock_gen_ch.sv
// clock_gen_ch: one divided-clock channel. Holds the active period/high-time,
// a shadow copy written by the host and a pending flag; the shadow is only
// taken over at a period boundary (or while disabled) so a running period
// never changes length.
// Build option: CLOCK_GEN_DUTY_EN selects host-programmed high time; without
// it the high time is always div>>1 and wr_high_i is ignored.
module clock_gen_ch
  import clock_gen_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  input  logic [CNT_W-1:0] wr_high_i,
  output logic             clk_out_o,
  output logic             tick_o
);

  localparam ch_cfg_t RST_CFG = '{div: CFG_W'(DIV_RST), high: CFG_W'(DIV_RST >> 1)};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  ch_cfg_t          activeCfg_q, activeCfg_d;
  ch_cfg_t          shadowCfg_q, shadowCfg_d;
  logic             pending_q, pending_d;
  logic             clkOut_q, clkOut_d;
  logic             tick_q, tick_d;

  logic [CFG_W-1:0] wrDiv;
  logic [CFG_W-1:0] wrHigh;
  logic             periodEnd;

  assign wrDiv = clampDiv(CFG_W'(wr_div_i));

`ifdef CLOCK_GEN_DUTY_EN
  assign wrHigh = clampHigh(CFG_W'(wr_high_i), wrDiv);
`else
  logic unused_wrHigh;
  assign unused_wrHigh = ^wr_high_i;
  assign wrHigh = wrDiv >> 1;
`endif

  assign periodEnd = (CFG_W'(cnt_q) == (activeCfg_q.div - CFG_W'(1)));

  // Next-state: counter advance, boundary/disabled config takeover, host writes
  always_comb begin
    cnt_d       = cnt_q;
    activeCfg_d = activeCfg_q;
    shadowCfg_d = shadowCfg_q;
    pending_d   = pending_q;
    clkOut_d    = 1'b0;
    tick_d      = 1'b0;

    if (!en_i) begin
      if (pending_q) begin
        activeCfg_d = shadowCfg_q;
        pending_d   = 1'b0;
      end
      cnt_d = CNT_W'(activeCfg_d.div - CFG_W'(1));
    end else begin
      if (periodEnd || sync_i) begin
        cnt_d = '0;
        if (pending_q) begin
          activeCfg_d = shadowCfg_q;
          pending_d   = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      clkOut_d = (CFG_W'(cnt_d) < activeCfg_d.high);
      tick_d   = (cnt_d == '0);
    end

    if (wr_i) begin
      shadowCfg_d.div  = wrDiv;
      shadowCfg_d.high = wrHigh;
      pending_d        = 1'b1;
    end
  end

  // Channel state register; reset drops any partial period and pending write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= CNT_W'(DIV_RST - 1);
      activeCfg_q <= RST_CFG;
      shadowCfg_q <= RST_CFG;
      pending_q   <= 1'b0;
      clkOut_q    <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      activeCfg_q <= activeCfg_d;
      shadowCfg_q <= shadowCfg_d;
      pending_q   <= pending_d;
      clkOut_q    <= clkOut_d;
      tick_q      <= tick_d;
    end
  end

  assign clk_out_o = clkOut_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clock_gen_multi.sv
// clock_gen_multi: N_CH independent registered clock dividers on one system
// clock. The top decodes host writes to a single channel and fans the sync
// restart out to every channel. Outputs are data/enables, not clock nets.
// Build option: CLOCK_GEN_DUTY_EN enables programmable high time (see
// clock_gen_ch); ports are the same in both builds.
module clock_gen_multi
  import clock_gen_pkg::*;
#(
  parameter int  N_CH    = 4,
  parameter int  CNT_W   = CNT_W_DEF,
  parameter int  DIV_RST = 10,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_high,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  logic [N_CH-1:0] wrSel;

  // Write decode: channel numbers at or above N_CH match no channel
  always_comb begin
    wrSel = '0;
    for (int i = 0; i < N_CH; i++) begin
      wrSel[i] = wr_en && (wr_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : gCh
    clock_gen_ch #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) uCh (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (en[g]),
      .sync_i    (sync),
      .wr_i      (wrSel[g]),
      .wr_div_i  (wr_div),
      .wr_high_i (wr_high),
      .clk_out_o (clk_out[g]),
      .tick_o    (tick[g])
    );
  end

endmodule

// File: tb/tb_clock_gen_multi.sv
// tb_clock_gen_multi: directed and randomized checks of clock_gen_multi
// against a period/phase model of each channel.
// Build option: CLOCK_GEN_DUTY_EN changes the expected high time.
module tb_clock_gen_multi;

  localparam int N_CH    = 3;
  localparam int CNT_W   = 16;
  localparam int DIV_RST = 10;
  localparam int CH_W    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_CH-1:0]  en;
  logic             sync;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic [CNT_W-1:0] wr_high;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model: per channel, period length, high length, position inside the
  // period, and the host value waiting for the next period.
  int  mPer[N_CH];
  int  mHigh[N_CH];
  int  mPos[N_CH];
  int  mNextPer[N_CH];
  int  mNextHigh[N_CH];
  bit  mWaiting[N_CH];
  logic [N_CH-1:0] expOut;
  logic [N_CH-1:0] expTick;

  clock_gen_multi #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .DIV_RST (DIV_RST)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sync    (sync),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .wr_high (wr_high),
    .clk_out (clk_out),
    .tick    (tick)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  function automatic int expectedHigh(input int per, input int high);
`ifdef CLOCK_GEN_DUTY_EN
    if (high < 1) return 1;
    if (high > per - 1) return per - 1;
    return high;
`else
    return per / 2;
`endif
  endfunction

  task automatic modelReset();
    for (int c = 0; c < N_CH; c++) begin
      mPer[c]      = DIV_RST;
      mHigh[c]     = DIV_RST / 2;
      mPos[c]      = DIV_RST - 1;
      mNextPer[c]  = DIV_RST;
      mNextHigh[c] = DIV_RST / 2;
      mWaiting[c]  = 1'b0;
    end
    expOut  = '0;
    expTick = '0;
  endtask

  // Advance the model across one clock edge using the inputs about to be sampled
  task automatic modelStep();
    for (int c = 0; c < N_CH; c++) begin
      if (!en[c]) begin
        if (mWaiting[c]) begin
          mPer[c]     = mNextPer[c];
          mHigh[c]    = mNextHigh[c];
          mWaiting[c] = 1'b0;
        end
        mPos[c]    = mPer[c] - 1;
        expOut[c]  = 1'b0;
        expTick[c] = 1'b0;
      end else begin
        if (mPos[c] == mPer[c] - 1 || sync) begin
          mPos[c] = 0;
          if (mWaiting[c]) begin
            mPer[c]     = mNextPer[c];
            mHigh[c]    = mNextHigh[c];
            mWaiting[c] = 1'b0;
          end
        end else begin
          mPos[c] = mPos[c] + 1;
        end
        expOut[c]  = (mPos[c] < mHigh[c]);
        expTick[c] = (mPos[c] == 0);
      end
      if (wr_en && int'(wr_ch) == c) begin
        mNextPer[c]  = (int'(wr_div) < 2) ? 2 : int'(wr_div);
        mNextHigh[c] = expectedHigh(mNextPer[c], int'(wr_high));
        mWaiting[c]  = 1'b1;
      end
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic checkOutput();
    testsRun++;
    if (clk_out !== expOut) begin
      testsFailed++;
      $display("[TB] FAIL clk_out at %0t: got %b, expected %b", $time, clk_out, expOut);
    end
    testsRun++;
    if (tick !== expTick) begin
      testsFailed++;
      $display("[TB] FAIL tick at %0t: got %b, expected %b", $time, tick, expTick);
    end
  endtask

  // One clock cycle: update model, cross the edge, compare on the falling edge
  task automatic applyStimulus();
    if (rst_n) modelStep();
    else       modelReset();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic writeCfg(input int ch, input int div, input int high);
    wr_en   = 1'b1;
    wr_ch   = CH_W'(ch);
    wr_div  = CNT_W'(div);
    wr_high = CNT_W'(high);
    applyStimulus();
    wr_en   = 1'b0;
  endtask

  task automatic runToTick(input int ch, output int steps);
    steps = 0;
    while (steps < 200) begin
      applyStimulus();
      steps++;
      if (tick[ch]) return;
    end
    checkValue("tickTimeout", 0, 1);
  endtask

  // Starting on a tick cycle, measure period and high length up to the next tick
  task automatic measurePeriod(input int ch, output int period, output int highLen);
    int steps;
    period  = 1;
    highLen = clk_out[ch] ? 1 : 0;
    steps   = 0;
    while (steps < 200) begin
      applyStimulus();
      steps++;
      if (tick[ch]) return;
      period++;
      if (clk_out[ch]) highLen++;
    end
    checkValue("periodTimeout", 0, 1);
  endtask

  int per, hi, steps;
  int expHigh8;

  initial begin
    rst_n   = 1'b0;
    en      = '0;
    sync    = 1'b0;
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_div  = '0;
    wr_high = '0;
    modelReset();

    @(negedge clk);
    checkValue("resetClkOut", int'(clk_out), 0);
    checkValue("resetTick", int'(tick), 0);
    applyStimulus();
    rst_n = 1'b1;
    idle(2);

    // Default divisor on channel 0: first tick one cycle after enable
    en = 3'b001;
    applyStimulus();
    checkValue("firstTick", int'(tick[0]), 1);
    checkValue("firstHigh", int'(clk_out[0]), 1);
    measurePeriod(0, per, hi);
    checkValue("defaultPeriod", per, 10);
    checkValue("defaultHigh", hi, 5);
    measurePeriod(0, per, hi);
    checkValue("defaultPeriod2", per, 10);

    // Mid-period write on channel 1 leaves the running period intact
    en = 3'b011;
    applyStimulus();
    checkValue("ch1FirstTick", int'(tick[1]), 1);
    idle(3);
    writeCfg(1, 7, 3);
    runToTick(1, steps);
    checkValue("inProgressPeriod", steps, 6);
    measurePeriod(1, per, hi);
    checkValue("ch1NewPeriod", per, 7);
    checkValue("ch1NewHigh", hi, 3);

    // Channel 2 high-time programming and clamping
`ifdef CLOCK_GEN_DUTY_EN
    expHigh8 = 2;
`else
    expHigh8 = 4;
`endif
    writeCfg(2, 8, 2);
    en = 3'b111;
    applyStimulus();
    checkValue("ch2FirstTick", int'(tick[2]), 1);
    measurePeriod(2, per, hi);
    checkValue("ch2Period8", per, 8);
    checkValue("ch2High8", hi, expHigh8);
    writeCfg(2, 8, 0);
    runToTick(2, steps);
    measurePeriod(2, per, hi);
    checkValue("ch2PeriodHigh0", per, 8);
`ifdef CLOCK_GEN_DUTY_EN
    checkValue("ch2HighClampLow", hi, 1);
`else
    checkValue("ch2HighClampLow", hi, 4);
`endif
    writeCfg(2, 0, 0);
    runToTick(2, steps);
    measurePeriod(2, per, hi);
    checkValue("ch2PeriodMin", per, 2);
    checkValue("ch2HighMin", hi, 1);

    // Sync aligns enabled channels; disabled channel stays low
    en = 3'b011;
    idle(3);
    sync = 1'b1;
    applyStimulus();
    sync = 1'b0;
    checkValue("syncTick", int'(tick), 3);
    checkValue("syncClkOut", int'(clk_out), 3);

    // Write landing on a boundary edge takes effect one period later
    runToTick(0, steps);
    idle(9);
    writeCfg(0, 6, 3);
    checkValue("boundaryTick", int'(tick[0]), 1);
    measurePeriod(0, per, hi);
    checkValue("boundaryOldPeriod", per, 10);
    measurePeriod(0, per, hi);
    checkValue("boundaryNewPeriod", per, 6);
    checkValue("boundaryNewHigh", hi, 3);

    // Write to a nonexistent channel changes nothing
    writeCfg(3, 4, 2);
    runToTick(0, steps);
    measurePeriod(0, per, hi);
    checkValue("badChPeriod0", per, 6);
    runToTick(1, steps);
    measurePeriod(1, per, hi);
    checkValue("badChPeriod1", per, 7);

    // Reset mid-period with a pending write
    writeCfg(0, 4, 2);
    idle(2);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkValue("asyncResetClkOut", int'(clk_out), 0);
    checkValue("asyncResetTick", int'(tick), 0);
    en = 3'b001;
    @(negedge clk);
    applyStimulus();
    rst_n = 1'b1;
    applyStimulus();
    checkValue("postResetTick", int'(tick[0]), 1);
    measurePeriod(0, per, hi);
    checkValue("postResetPeriod", per, 10);
    checkValue("postResetHigh", hi, 5);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
      end
      sync    = ($urandom_range(0, 39) == 0);
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_ch   = CH_W'($urandom_range(0, 3));
      wr_div  = CNT_W'($urandom_range(0, 12));
      wr_high = CNT_W'($urandom_range(0, 12));
      applyStimulus();
    end
    sync  = 1'b0;
    wr_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/clock_gen_multi.md
CLOCK_GEN_MULTI -- requirements
Module: clock_gen_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent divided-clock channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16, width of divisor, high-time and period counters.
REQ-003 SHALL have parameter DIV_RST, default 10, divisor loaded into every channel at reset.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on posedge clk.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, N_CH, per-channel run enable.
REQ-007 SHALL have port sync, input, 1, restarts the period of all enabled channels.
REQ-008 SHALL have port wr_en, input, 1, one-cycle configuration write strobe.
REQ-009 SHALL have port wr_ch, input, $clog2(N_CH) (min 1), target channel.
REQ-010 SHALL have port wr_div, input, CNT_W, period in clk cycles.
REQ-011 SHALL have port wr_high, input, CNT_W, high-time in clk cycles (see REQ-027).
REQ-012 SHALL have port clk_out, output, N_CH, registered divided clocks, used as data or enables and never as clock nets.
REQ-013 SHALL have port tick, output, N_CH, one-cycle pulse aligned with each clk_out rising edge.

Function
REQ-014 Per channel: active D/H registers, pending shadow D/H registers and a pending flag; counter cnt over 0..D-1.
REQ-015 Write path: wr_en=1 with wr_ch<N_CH SHALL capture the clamped values into that channel's shadow and set pending; wr_ch>=N_CH is ignored.
REQ-016 Clamping: D = max(wr_div,2); H clamped to 1..D-1.
REQ-017 Enabled edge: next_cnt = 0 if cnt==D-1 or sync=1, else cnt+1.
REQ-018 Outputs: clk_out <= (next_cnt < H); tick <= (next_cnt == 0).
REQ-019 Disabled (en=0): cnt <= D-1, clk_out <= 0, tick <= 0; a pending shadow is applied immediately.
REQ-020 Enable rise: the first enabled edge gives next_cnt=0, so clk_out and tick go high exactly one cycle after en is sampled high.
REQ-021 Boundary load: on any enabled edge with next_cnt==0, if pending, D/H SHALL load from the pre-edge shadow and pending SHALL clear; a write on that same edge goes to the shadow for the following boundary.
REQ-022 Glitch-free update: a period in progress never changes length; after any write, the next full period uses the new values.
REQ-023 Sync with write on the same edge: sync restarts the period with the pre-edge shadow; the new write stays pending.
REQ-024 Counter SHALL never exceed D-1; no wrap beyond 2^CNT_W is reachable because D <= 2^CNT_W-1.

Reset
REQ-025 rst_n low SHALL asynchronously set cnt=DIV_RST-1, D=DIV_RST, H=DIV_RST>>1, shadow=active, pending=0, clk_out=0, tick=0; release is synchronous to clk.
REQ-026 Reset mid-period SHALL discard the partial period and pending writes.

Configuration
REQ-027 Macro CLOCK_GEN_DUTY_EN: when defined, H SHALL come from wr_high (clamped per REQ-016); when undefined, wr_high SHALL be ignored and H=D>>1 (odd D gives a shorter high phase); ports are identical in both builds.

Structure
REQ-028 Package clock_gen_pkg SHALL hold the CNT_W default, the DIV_MIN=2 constant and the channel config struct {div, high}.
REQ-029 Sub-module clock_gen_ch SHALL implement one channel (REQ-014..024); the top SHALL do write decode, sync fan-out and N_CH instantiation.

Verification
REQ-030 Reset, en[0]=1, D=10 default -> clk_out[0] high 5 / low 5 cycles, tick every 10 cycles, first tick 1 cycle after en.
REQ-031 Write ch1 div=7 mid-period (CLOCK_GEN_DUTY_EN off) -> current period completes unchanged, then high 3 / low 4.
REQ-032 DUTY_EN on, write ch2 div=8 high=2 -> high 2 / low 6; write high=0 -> high 1; write div=0 -> period 2.
REQ-033 sync pulse with channels at differing phases -> all enabled channels tick on the same cycle; disabled channels stay 0.
REQ-034 Write and boundary on the same edge -> new value applied one period later; write wr_ch=N_CH -> no channel changes.
REQ-035 rst_n asserted mid-period with a write pending -> clk_out=0 immediately; after release, period = DIV_RST.
